// File: rtl/tick_pkg.sv
// Shared definitions for tick_prescaler: FSM state encoding and default ratio width.
package tick_pkg;

    localparam int unsigned DIV_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

endpackage

// File: rtl/tick_prescaler_if.sv
// Control/status bundle of tick_prescaler; step exists only with TICK_PRESCALER_STEP_EN.
interface tick_prescaler_if #(
    parameter int unsigned DIV_W = tick_pkg::DIV_W_DEFAULT
);
    logic             start;
    logic             stop;
    logic             hold;
`ifdef TICK_PRESCALER_STEP_EN
    logic             step;
`endif
    logic [DIV_W-1:0] div;
    logic             tick;
    logic             busy;

`ifdef TICK_PRESCALER_STEP_EN
    modport master (output start, stop, hold, step, div, input tick, busy);
    modport slave  (input start, stop, hold, step, div, output tick, busy);
`else
    modport master (output start, stop, hold, div, input tick, busy);
    modport slave  (input start, stop, hold, div, output tick, busy);
`endif

endinterface

// File: rtl/tick_prescaler_pulse_edge.sv
// Registers a level and flags its rising edge for one clock.
module pulse_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise_c
);

    logic level_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise_c = level & ~level_q;

endmodule

// File: rtl/tick_prescaler.sv
// Divide-by-N count-enable generator with run/pause/idle control.
// Define TICK_PRESCALER_STEP_EN to add a manual single-step tick input.
module tick_prescaler
    import tick_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    tick_prescaler_if.slave bus
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    state_e           state_q;
    state_e           state_d;
    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;
    logic [DIV_W-1:0] ratio_q;
    logic [DIV_W-1:0] ratio_d;
    logic [DIV_W-1:0] div_ratio_c;
    logic             tick_q;
    logic             tick_d;
    logic             busy_q;
    logic             step_tick_c;

    // A ratio of zero behaves as divide-by-one.
    assign div_ratio_c = (bus.div == '0) ? ONE : bus.div;

`ifdef TICK_PRESCALER_STEP_EN
    logic step_rise_c;

    pulse_edge u_step_edge (
        .clk    (clk),
        .reset  (reset),
        .level  (bus.step),
        .rise_c (step_rise_c)
    );

    assign step_tick_c = step_rise_c && (state_q != RUN);
`else
    assign step_tick_c = 1'b0;
`endif

    // Next state, divider count and tick; stop outranks hold and terminal count.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ratio_d = ratio_q;
        tick_d  = step_tick_c;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = RUN;
                    count_d = '0;
                    ratio_d = div_ratio_c;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    count_d = '0;
                    tick_d  = 1'b0;
                end else if (bus.hold) begin
                    state_d = PAUSE;
                end else if (count_q == ratio_q - ONE) begin
                    count_d = '0;
                    ratio_d = div_ratio_c;
                    tick_d  = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    count_d = '0;
                    tick_d  = 1'b0;
                end else if (!bus.hold) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                ratio_d = ONE;
                tick_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            ratio_q <= ONE;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ratio_q <= ratio_d;
            tick_q  <= tick_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.tick = tick_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_tick_prescaler.sv
// Scoreboard bench for tick_prescaler: expected tick cycles are queued by stimulus, popped by a monitor.
module tb_tick_prescaler;

    localparam int unsigned DW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_q[$];
    int   c;

    tick_prescaler_if #(.DIV_W(DW)) bus ();

    tick_prescaler #(.DIV_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every observed tick must match the oldest expected tick cycle.
    always @(negedge clk) begin
        if (bus.tick === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_tick: tick seen at cycle %0d, required no tick", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (e != cyc) begin
                    n_bad++;
                    $display("FAIL tick_cycle: tick seen at cycle %0d, required cycle %0d", cyc, e);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic at(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic expect_ticks(input int first, input int period, input int num);
        for (int i = 0; i < num; i++) exp_q.push_back(first + i * period);
    endtask

    // Raises start for one cycle; returns the cycle number at which start was applied.
    task automatic do_start(input int d, output int c0);
        bus.div   = DW'(d);
        bus.start = 1'b1;
        c0        = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic stop_at(input int t, input string name);
        at(t);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check({name, "_busy_after_stop"}, int'(bus.busy), 0);
        check({name, "_tick_after_stop"}, int'(bus.tick), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.hold  = 1'b0;
        bus.div   = '0;
`ifdef TICK_PRESCALER_STEP_EN
        bus.step  = 1'b0;
`endif
        reset = 1'b0;
        #12;
        check("reset_tick", int'(bus.tick), 0);
        check("reset_busy", int'(bus.busy), 0);
        #8 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // div=4: first tick 4 clocks after the start edge, then every 4
        do_start(4, c);
        expect_ticks(c + 5, 4, 3);
        check("div4_busy", int'(bus.busy), 1);
        stop_at(c + 14, "div4");
        at(c + 18);

        // div=0 and div=1 both tick on every RUN cycle
        do_start(0, c);
        expect_ticks(c + 2, 1, 6);
        check("div0_busy", int'(bus.busy), 1);
        stop_at(c + 7, "div0");
        at(c + 10);
        do_start(1, c);
        expect_ticks(c + 2, 1, 6);
        stop_at(c + 7, "div1");
        at(c + 10);

        // div=5 held at count 2 for 7 clocks, resumes from the frozen count
        do_start(5, c);
        at(c + 3);
        bus.hold = 1'b1;
        expect_ticks(c + 14, 5, 2);
        at(c + 7);
        check("hold_busy", int'(bus.busy), 1);
        at(c + 10);
        bus.hold = 1'b0;
        stop_at(c + 20, "hold");
        at(c + 23);

        // stop and start together on the terminal-count cycle
        do_start(3, c);
        expect_ticks(c + 4, 3, 1);
        at(c + 6);
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        check("stop_start_busy", int'(bus.busy), 0);
        check("stop_start_tick", int'(bus.tick), 0);
        at(c + 12);

        // ratio change mid-period takes effect on the following period
        do_start(4, c);
        expect_ticks(c + 5, 4, 2);
        at(c + 6);
        bus.div = DW'(2);
        expect_ticks(c + 11, 2, 2);
        stop_at(c + 14, "ratio_change");
        at(c + 18);

`ifdef TICK_PRESCALER_STEP_EN
        // step in PAUSE yields one tick and leaves state and count intact
        do_start(4, c);
        at(c + 2);
        bus.hold = 1'b1;
        at(c + 4);
        bus.step = 1'b1;
        expect_ticks(c + 5, 1, 1);
        at(c + 5);
        bus.step = 1'b0;
        at(c + 6);
        check("step_busy", int'(bus.busy), 1);
        at(c + 7);
        bus.hold = 1'b0;
        expect_ticks(c + 11, 4, 1);
        stop_at(c + 12, "step");
        at(c + 16);
`endif

        // asynchronous reset mid-period with div=6
        do_start(6, c);
        expect_ticks(c + 7, 6, 1);
        at(c + 9);
        check("prereset_busy", int'(bus.busy), 1);
        #1 reset = 1'b0;
        #1;
        check("async_reset_tick", int'(bus.tick), 0);
        check("async_reset_busy", int'(bus.busy), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check("post_reset_busy", int'(bus.busy), 0);

        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            int e;
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_tick: no tick seen, required one at cycle %0d", e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
